binop_sched: RTL and testbench

Two-requester scheduler that shares one binary-operator unit. It covers the same-size add, sub, shift, multiply, bitwise, relational, equality and logical operators, in unsigned and signed forms. Requests are arbitrated round-robin. Single-cycle ops and an iterative shift-add multiplier are sequenced through a small FSM, and each result is returned on one valid/ready response channel tagged with the requester id. It is the controller that lets several clients reuse one operator datapath instead of instantiating one per client.

---
 rtl/binop_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_binop_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/binop_sched.sv
// rtl/binop_sched.sv - two-requester round-robin scheduler sharing one binary-operator unit
module binop_sched #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic            req0_signed,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic            req1_signed,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [SIZE-1:0] rsp_data,
    output logic            rsp_flag,
    output logic            busy
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_LT   = 4'd8;
    localparam logic [3:0] OP_LTE  = 4'd9;
    localparam logic [3:0] OP_GT   = 4'd10;
    localparam logic [3:0] OP_GTE  = 4'd11;
    localparam logic [3:0] OP_EQ   = 4'd12;
    localparam logic [3:0] OP_NEQ  = 4'd13;
    localparam logic [3:0] OP_LAND = 4'd14;
    localparam logic [3:0] OP_LOR  = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_ptr;
    logic            r_id;
    logic            r_rsp_valid;
    logic            r_busy;
    logic [SIZE-1:0] r_rsp_data;
    logic            r_rsp_flag;
    logic [SIZE-1:0] r_acc;
    logic [SIZE-1:0] r_mcand;
    logic [SIZE-1:0] r_mplier;
    logic [5:0]      r_cnt;

    logic            w_idle;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_accept;
    logic [3:0]      w_op;
    logic            w_sgn;
    logic [SIZE-1:0] w_a;
    logic [SIZE-1:0] w_b;
    logic [SIZE-1:0] w_alu_data;
    logic            w_alu_flag;
    logic            w_bool;
    logic            w_is_bool;
    logic            w_shamt_big;
    logic [SIZE-1:0] w_acc_next;

    // Grant: the pointer picks the favoured requester; a lone valid always wins.
    assign w_idle   = (r_state == S_IDLE);
    assign w_gnt0   = req0_valid && (!req1_valid || !r_ptr);
    assign w_gnt1   = req1_valid && (!req0_valid ||  r_ptr);
    assign w_accept = w_idle && (w_gnt0 || w_gnt1);

    // Readies are gated by reset so they read 0 while rst_n is asserted.
    assign req0_ready = rst_n && w_idle && w_gnt0;
    assign req1_ready = rst_n && w_idle && w_gnt1;

    assign w_op  = w_gnt1 ? req1_op     : req0_op;
    assign w_sgn = w_gnt1 ? req1_signed : req0_signed;
    assign w_a   = w_gnt1 ? req1_a      : req0_a;
    assign w_b   = w_gnt1 ? req1_b      : req0_b;

    // Single-cycle operator datapath evaluated on the granted payload.
    always_comb begin
        w_alu_data  = '0;
        w_bool      = 1'b0;
        w_is_bool   = 1'b0;
        w_shamt_big = (33'(w_b) >= 33'(SIZE));
        case (w_op)
            OP_ADD:  w_alu_data = w_a + w_b;
            OP_SUB:  w_alu_data = w_a - w_b;
            OP_SHL:  w_alu_data = w_shamt_big ? '0 : (w_a << w_b);
            OP_SHR:  w_alu_data = w_shamt_big ? '0 : (w_a >> w_b);
            OP_MUL:  w_alu_data = '0;
            OP_AND:  w_alu_data = w_a & w_b;
            OP_XOR:  w_alu_data = w_a ^ w_b;
            OP_OR:   w_alu_data = w_a | w_b;
            OP_LT: begin
                w_is_bool = 1'b1;
                w_bool    = w_sgn ? ($signed(w_a) <  $signed(w_b)) : (w_a <  w_b);
            end
            OP_LTE: begin
                w_is_bool = 1'b1;
                w_bool    = w_sgn ? ($signed(w_a) <= $signed(w_b)) : (w_a <= w_b);
            end
            OP_GT: begin
                w_is_bool = 1'b1;
                w_bool    = w_sgn ? ($signed(w_a) >  $signed(w_b)) : (w_a >  w_b);
            end
            OP_GTE: begin
                w_is_bool = 1'b1;
                w_bool    = w_sgn ? ($signed(w_a) >= $signed(w_b)) : (w_a >= w_b);
            end
            OP_EQ: begin
                w_is_bool = 1'b1;
                w_bool    = (w_a == w_b);
            end
            OP_NEQ: begin
                w_is_bool = 1'b1;
                w_bool    = (w_a != w_b);
            end
            OP_LAND: begin
                w_is_bool = 1'b1;
                w_bool    = (|w_a) && (|w_b);
            end
            OP_LOR: begin
                w_is_bool = 1'b1;
                w_bool    = (|w_a) || (|w_b);
            end
            default: w_alu_data = '0;
        endcase
        if (w_is_bool) begin
            w_alu_data    = '0;
            w_alu_data[0] = w_bool;
        end
        w_alu_flag = w_is_bool ? w_bool : (w_alu_data == '0);
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    end

    // Scheduler FSM: arbitrate and latch in IDLE, iterate mul in EXEC, hold the response in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flag  <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id     <= w_gnt1;
                        r_ptr    <= ~w_gnt1;
                        r_busy   <= 1'b1;
                        r_mcand  <= w_a;
                        r_mplier <= w_b;
                        if (w_op == OP_MUL) begin
                            r_state <= S_EXEC;
                            r_acc   <= '0;
                            r_cnt   <= 6'(SIZE - 1);
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_alu_data;
                            r_rsp_flag  <= w_alu_flag;
                        end
                    end
                end
                S_EXEC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == 6'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_acc_next;
                        r_rsp_flag  <= (w_acc_next == '0);
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_flag  = r_rsp_flag;
    assign busy      = r_busy;

endmodule

// File: tb/tb_binop_sched.sv
// tb/tb_binop_sched.sv - scoreboard bench for binop_sched at SIZE=4
module tb_binop_sched;

    localparam int SIZE = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [3:0]      req0_op = '0, req1_op = '0;
    logic            req0_signed = 1'b0, req1_signed = 1'b0;
    logic [SIZE-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_id;
    logic [SIZE-1:0] rsp_data;
    logic            rsp_flag;
    logic            busy;

    typedef struct packed {
        logic            id;
        logic [SIZE-1:0] data;
        logic            flag;
    } exp_t;

    exp_t sbq[$];
    int   grants[$];
    int   rsp_ids[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    binop_sched #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_signed(req0_signed), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_signed(req1_signed), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic id, input logic [3:0] op, input logic sg,
                                   input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        exp_t   e;
        longint ua, ub, ra, rb;
        logic   bl, isb;
        ua = longint'(a);
        ub = longint'(b);
        ra = (sg && a[SIZE-1]) ? ua - (longint'(1) << SIZE) : ua;
        rb = (sg && b[SIZE-1]) ? ub - (longint'(1) << SIZE) : ub;
        isb = (op >= 4'd8);
        bl = 1'b0;
        e.data = '0;
        case (op)
            4'd0:  e.data = SIZE'(ua + ub);
            4'd1:  e.data = SIZE'(ua - ub);
            4'd2:  e.data = (ub >= SIZE) ? '0 : SIZE'(ua << ub);
            4'd3:  e.data = (ub >= SIZE) ? '0 : SIZE'(ua >> ub);
            4'd4:  e.data = SIZE'(ua * ub);
            4'd5:  e.data = a & b;
            4'd6:  e.data = a ^ b;
            4'd7:  e.data = a | b;
            4'd8:  bl = (ra <  rb);
            4'd9:  bl = (ra <= rb);
            4'd10: bl = (ra >  rb);
            4'd11: bl = (ra >= rb);
            4'd12: bl = (ua == ub);
            4'd13: bl = (ua != ub);
            4'd14: bl = (ua != 0) && (ub != 0);
            default: bl = (ua != 0) || (ub != 0);
        endcase
        if (isb) e.data = SIZE'(bl);
        e.flag = isb ? bl : (e.data == '0);
        e.id = id;
        return e;
    endfunction

    // One clock: observe at the falling edge, then advance past the rising edge.
    task automatic tick();
        exp_t e;
        logic acc0, acc1;
        @(negedge clk);
        chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0) begin
            sbq.push_back(model(1'b0, req0_op, req0_signed, req0_a, req0_b));
            grants.push_back(0);
        end
        if (acc1) begin
            sbq.push_back(model(1'b1, req1_op, req1_signed, req1_a, req1_b));
            grants.push_back(1);
        end
        if (rsp_valid && sbq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        if (rsp_valid && rsp_ready && sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_flag", 32'(rsp_flag), 32'(e.flag));
            rsp_ids.push_back(int'(rsp_id));
        end
        @(posedge clk);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic drive(input int id, input logic [3:0] op, input logic sg,
                         input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        if (id == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_signed = sg; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_signed = sg; req1_a = a; req1_b = b;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (sbq.size() != 0 || req0_valid || req1_valid || rsp_valid); i++) tick();
        chk("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    task automatic run_op(input int id, input logic [3:0] op, input logic sg,
                          input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        drive(id, op, sg, a, b);
        rsp_ready = 1'b1;
        drain();
    endtask

    initial begin
        int k;
        exp_t e;

        // reset state, with both requesters asserting valid
        drive(0, 4'd0, 1'b0, 4'h1, 4'h1);
        drive(1, 4'd0, 1'b0, 4'h2, 4'h2);
        tick();
        tick();
        chk("reset_outputs", {26'd0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_flag, busy}, 32'd0);
        chk("reset_data", 32'(rsp_data), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // add with wrap: response one cycle after accept
        drive(0, 4'd0, 1'b0, 4'hF, 4'h1);
        tick();
        chk("add_rsp_valid_T1", 32'(rsp_valid), 32'd1);
        chk("add_busy_T1", 32'(busy), 32'd1);
        chk("add_data", 32'(rsp_data), 32'h0);
        chk("add_flag", 32'(rsp_flag), 32'd1);
        drain();
        chk("idle_after_add", 32'(busy), 32'd0);

        // signed vs unsigned lt
        run_op(0, 4'd8, 1'b1, 4'b1000, 4'b0001);
        run_op(0, 4'd8, 1'b0, 4'b1000, 4'b0001);

        // multiply latency: rsp_valid exactly SIZE+1 cycles after accept
        drive(0, 4'd4, 1'b0, 4'h3, 4'h5);
        tick();
        chk("mul_busy_exec", 32'(busy), 32'd1);
        k = 1;
        while (!rsp_valid && k < 40) begin
            tick();
            k++;
        end
        chk("mul_latency", 32'(k), 32'(SIZE + 1));
        chk("mul_3x5", 32'(rsp_data), 32'hF);
        drain();

        // more operator coverage, including boundaries
        run_op(0, 4'd4, 1'b1, 4'hF, 4'hF);
        run_op(1, 4'd2, 1'b0, 4'h1, 4'd4);
        run_op(0, 4'd2, 1'b0, 4'h3, 4'd1);
        run_op(1, 4'd3, 1'b1, 4'h8, 4'd3);
        run_op(0, 4'd1, 1'b0, 4'h2, 4'h5);
        run_op(1, 4'd11, 1'b1, 4'hF, 4'h1);
        run_op(0, 4'd10, 1'b0, 4'hF, 4'h1);
        run_op(1, 4'd9, 1'b1, 4'h7, 4'h7);
        run_op(0, 4'd12, 1'b0, 4'h5, 4'h5);
        run_op(1, 4'd13, 1'b0, 4'h5, 4'h5);
        run_op(0, 4'd14, 1'b0, 4'h5, 4'h0);
        run_op(1, 4'd15, 1'b0, 4'h0, 4'h2);
        run_op(0, 4'd6, 1'b0, 4'hC, 4'hC);
        run_op(1, 4'd7, 1'b0, 4'h9, 4'h4);
        run_op(0, 4'd5, 1'b0, 4'hC, 4'h6);

        // round-robin with both requesters held valid, after a fresh reset
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        grants.delete();
        rsp_ids.delete();
        rsp_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (!req0_valid) drive(0, 4'd0, 1'b0, SIZE'(k), 4'h1);
            if (!req1_valid) drive(1, 4'd0, 1'b0, SIZE'(k + 8), 4'h2);
            k++;
            tick();
        end
        drain();
        if (grants.size() >= 4 && rsp_ids.size() >= 4) begin
            chk("rr_grants", 32'({grants[0][0], grants[1][0], grants[2][0], grants[3][0]}), 32'b0101);
            chk("rr_rsp_ids", 32'({rsp_ids[0][0], rsp_ids[1][0], rsp_ids[2][0], rsp_ids[3][0]}), 32'b0101);
        end else begin
            chk("rr_count", 32'(grants.size()), 32'd4);
        end

        // response stall with a waiting requester
        rsp_ready = 1'b0;
        drive(0, 4'd6, 1'b0, 4'hA, 4'h3);
        tick();
        drive(1, 4'd0, 1'b0, 4'h1, 4'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'h9);
            chk("stall_id", 32'(rsp_id), 32'd0);
            chk("stall_readies", 32'({req0_ready, req1_ready}), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("stall_release_busy", 32'(busy), 32'd0);
        chk("stall_release_ready1", 32'(req1_ready), 32'd1);
        chk("stall_req1_waiting", 32'(req1_valid), 32'd1);
        drain();

        // reset during multiply: outputs clear at once, no response afterwards
        drive(0, 4'd4, 1'b0, 4'h3, 4'h5);
        tick();
        tick();
        chk("mid_mul_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {26'd0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_flag, busy}, 32'd0);
        chk("rst_mid_data", 32'(rsp_data), 32'd0);
        sbq.delete();
        tick();
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid) k++;
        end
        chk("no_rsp_after_reset", 32'(k), 32'd0);
        grants.delete();
        drive(0, 4'd0, 1'b0, 4'h2, 4'h3);
        drive(1, 4'd0, 1'b0, 4'h4, 4'h5);
        tick();
        if (grants.size() != 0) chk("first_grant_after_reset", 32'(grants[0]), 32'd0);
        else chk("first_grant_seen", 32'(grants.size()), 32'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
